// File: rtl/bcd_countdown_timer_if.sv
// rtl/bcd_countdown_timer_if.sv - button/switch/tick inputs and display outputs of the countdown core
interface bcd_countdown_timer_if;
    logic        tick_sec;
    logic        tick_blink;
    logic        pls_up;
    logic        pls_left;
    logic        pls_right;
    logic        pls_down;
    logic        sw0;
    logic        sw1;
    logic [15:0] bcd;
    logic        disp_en;
    logic        zero;

    modport master (
        output tick_sec, tick_blink, pls_up, pls_left, pls_right, pls_down, sw0, sw1,
        input  bcd, disp_en, zero
    );

    modport slave (
        input  tick_sec, tick_blink, pls_up, pls_left, pls_right, pls_down, sw0, sw1,
        output bcd, disp_en, zero
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - parking-meter countdown core with BCD output and zero-flash display enable
module bcd_countdown_timer #(
    parameter int ADD_UP    = 10,
    parameter int ADD_LEFT  = 180,
    parameter int ADD_RIGHT = 200,
    parameter int ADD_DOWN  = 550,
    parameter int PRESET0   = 15,
    parameter int PRESET1   = 185,
    parameter int MAX_COUNT = 9999
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    bcd_countdown_timer_if.slave  bus
);

    typedef enum logic {
        SOLID,
        FLASH
    } disp_state_e;

    // 15 bits so the worst-case unclamped sum (9999 + all four adds) cannot wrap
    localparam logic [14:0] ADD_UP_W    = 15'(ADD_UP);
    localparam logic [14:0] ADD_LEFT_W  = 15'(ADD_LEFT);
    localparam logic [14:0] ADD_RIGHT_W = 15'(ADD_RIGHT);
    localparam logic [14:0] ADD_DOWN_W  = 15'(ADD_DOWN);
    localparam logic [14:0] PRESET0_W   = 15'(PRESET0);
    localparam logic [14:0] PRESET1_W   = 15'(PRESET1);
    localparam logic [14:0] MAX_W       = 15'(MAX_COUNT);

    logic [14:0] count_q, count_d;
    logic [15:0] bcd_q, bcd_d;
    logic        zero_q, zero_d;
    logic        disp_en_q, disp_en_d;
    logic        phase_q, phase_d;
    disp_state_e state_q, state_d;

    logic [14:0] sum;
    logic [14:0] clamped;

    // Next count: presets override, otherwise add pulses, clamp, then the per-second decrement
    always_comb begin
        sum     = count_q
                + (bus.pls_up    ? ADD_UP_W    : 15'd0)
                + (bus.pls_left  ? ADD_LEFT_W  : 15'd0)
                + (bus.pls_right ? ADD_RIGHT_W : 15'd0)
                + (bus.pls_down  ? ADD_DOWN_W  : 15'd0);
        clamped = (sum > MAX_W) ? MAX_W : sum;
        count_d = clamped;
        if (bus.tick_sec && (clamped != 15'd0)) begin
            count_d = clamped - 15'd1;
        end
        if (bus.sw1) begin
            count_d = PRESET1_W;
        end else if (bus.sw0) begin
            count_d = PRESET0_W;
        end
    end

    // Binary to BCD by shift-and-add-3, MSB first, so bcd_q is always valid digits
    always_comb begin
        bcd_d = 16'h0000;
        for (int i = 14; i >= 0; i--) begin
            for (int k = 0; k < 4; k++) begin
                if (bcd_d[4*k +: 4] >= 4'd5) begin
                    bcd_d[4*k +: 4] = bcd_d[4*k +: 4] + 4'd3;
                end
            end
            bcd_d = {bcd_d[14:0], count_d[i]};
        end
    end

    // Display FSM: solid while counting, blink phase drives the enable once the count hits zero
    always_comb begin
        state_d   = state_q;
        phase_d   = 1'b0;
        disp_en_d = 1'b1;
        zero_d    = (count_d == 15'd0);
        case (state_q)
            SOLID: begin
                if (count_d == 15'd0) begin
                    state_d = FLASH;
                end
            end
            FLASH: begin
                if (count_d != 15'd0) begin
                    state_d = SOLID;
                end else begin
                    phase_d = phase_q ^ bus.tick_blink;
                end
            end
            default: state_d = FLASH;
        endcase
        if (state_d == FLASH) begin
            disp_en_d = phase_d;
        end
    end

    // All state and outputs registered; reset lands in FLASH with the display dark
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q   <= 15'd0;
            bcd_q     <= 16'h0000;
            zero_q    <= 1'b1;
            disp_en_q <= 1'b0;
            phase_q   <= 1'b0;
            state_q   <= FLASH;
        end else begin
            count_q   <= count_d;
            bcd_q     <= bcd_d;
            zero_q    <= zero_d;
            disp_en_q <= disp_en_d;
            phase_q   <= phase_d;
            state_q   <= state_d;
        end
    end

    assign bus.bcd     = bcd_q;
    assign bus.zero    = zero_q;
    assign bus.disp_en = disp_en_q;

endmodule
